pc_fetch_unit: RTL



---
 rtl/pc_fetch_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch-address register and next-PC selector with return-address stack and EPC capture.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
    parameter int               STEP         = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             exc_req,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump_valid,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call_push,
    input  logic [WIDTH-1:0] link_addr,
    input  logic             ret_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             fetch_valid,
    output logic             flush_if,
    output logic [WIDTH-1:0] epc,
    output logic             ras_empty,
    output logic             ret_miss,
    output logic             align_fault
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             fetch_valid_q;
    logic             ret_miss_q, ret_miss_d;
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic             act;
    logic             sel_exc, sel_br, sel_jmp, sel_ret;
    logic             push_en, pop_en;
    logic             misalign;
    logic [WIDTH-1:0] tgt;
    logic             ras_we;
    logic [PTR_W-1:0] ras_wa;

    assign pc_plus = pc_q + WIDTH'(STEP);

    // A stalled ID stage re-presents its requests later, so only exceptions get through.
    assign act     = !exc_req && !stall;
    assign sel_exc = exc_req;
    assign sel_br  = act && branch_taken;
    assign sel_jmp = act && !branch_taken && jump_valid;
    assign sel_ret = act && !branch_taken && !jump_valid && ret_req && (cnt_q != '0);
    assign push_en = act && call_push;
    assign pop_en  = sel_ret;

    assign tgt = sel_br  ? branch_target :
                 sel_jmp ? jump_target   : ras_q[top_q];

`ifdef PC_ALIGN_CHECK_EN
    assign misalign = (sel_br || sel_jmp || sel_ret) && (tgt[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        pc_d       = pc_plus;
        epc_d      = epc_q;
        top_d      = top_q;
        cnt_d      = cnt_q;
        ras_we     = 1'b0;
        ras_wa     = top_q;
        ret_miss_d = act && !branch_taken && !jump_valid && ret_req && (cnt_q == '0);

        if (sel_exc || misalign) begin
            pc_d = EXC_VECTOR;
        end else if (sel_br || sel_jmp || sel_ret) begin
            pc_d = tgt;
        end else if (stall) begin
            pc_d = pc_q;
        end

        if (sel_exc) begin
            epc_d = pc_q;
        end else if (misalign) begin
            epc_d = tgt;
        end

        // Push+pop together replaces the top entry in place; the redirect reads the old value.
        if (push_en && pop_en) begin
            ras_we = 1'b1;
            ras_wa = top_q;
        end else if (push_en) begin
            ras_we = 1'b1;
            ras_wa = top_q + PTR_W'(1);
            top_d  = top_q + PTR_W'(1);
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_en) begin
            top_d = top_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (sel_exc || misalign) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= RESET_VECTOR;
            epc_q         <= '0;
            fetch_valid_q <= 1'b0;
            ret_miss_q    <= 1'b0;
            top_q         <= '0;
            cnt_q         <= '0;
        end else begin
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            fetch_valid_q <= 1'b1;
            ret_miss_q    <= ret_miss_d;
            top_q         <= top_d;
            cnt_q         <= cnt_d;
        end
    end

    // Entries carry no reset; the count alone says which are live.
    always_ff @(posedge clock) begin
        if (!reset && ras_we) begin
            ras_q[ras_wa] <= link_addr;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic align_fault_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            align_fault_q <= 1'b0;
        end else begin
            align_fault_q <= misalign;
        end
    end
    assign align_fault = align_fault_q;
`else
    assign align_fault = 1'b0;
`endif

    assign pc          = pc_q;
    assign epc         = epc_q;
    assign fetch_valid = fetch_valid_q;
    assign ret_miss    = ret_miss_q;
    assign ras_empty   = (cnt_q == '0);
    assign flush_if    = !reset && (sel_exc || sel_br || sel_jmp || sel_ret);

endmodule
